// File: rtl/mem_pkg.sv
// Shared definitions for the memory response tracker.
// Contents:
//   OP_*          bit positions inside the 7-bit one-hot load op
//                 {right,left,uhalf,half,ubyte,byte,word}
//   LWL/LWR_STRB  byte-enable tables for partial-word loads, indexed by addr_lo
//   entry_t       one tracker FIFO entry
//   strb_lookup   picks a 4-bit strobe out of a packed table
package mem_pkg;

    localparam int OP_WORD  = 0;
    localparam int OP_BYTE  = 1;
    localparam int OP_UBYTE = 2;
    localparam int OP_HALF  = 3;
    localparam int OP_UHALF = 4;
    localparam int OP_LEFT  = 5;
    localparam int OP_RIGHT = 6;

    // Nibble n holds the strobe for addr_lo == n (nibble 0 is the LSBs).
    localparam logic [15:0] LWL_STRB_TBL = 16'b1111_1110_1100_1000;
    localparam logic [15:0] LWR_STRB_TBL = 16'b0001_0011_0111_1111;

    typedef struct packed {
        logic       load;
        logic [6:0] op;
        logic [1:0] addr_lo;
        logic [4:0] dest;
        logic       cancelled;
    } entry_t;

    function automatic logic [3:0] strb_lookup(input logic [15:0] tbl,
                                               input logic [1:0]  idx);
        return tbl[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: turns a raw 32-bit bus word into the GPR
// write value and byte enables for the recorded load op.
// Ports:
//   i_op       one-hot load op (bit positions from mem_pkg)
//   i_addr_lo  address bits [1:0] of the load
//   i_rdata    raw response data
//   o_data     aligned, sign/zero-extended result
//   o_wstrb    GPR byte write enables
module mem_load_align
    import mem_pkg::*;
(
    input  logic [6:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic [3:0]  o_wstrb
);

    logic [31:0] w_shr;
    logic [31:0] w_shl;

    // Shift amounts are byte counts scaled by 8; lwl shifts by the inverted offset.
    assign w_shr = i_rdata >> {i_addr_lo, 3'b000};
    assign w_shl = i_rdata << {~i_addr_lo, 3'b000};

    always_comb begin
        o_data  = i_rdata;
        o_wstrb = 4'b1111;
        if (i_op[OP_BYTE]) begin
            o_data = {{24{w_shr[7]}}, w_shr[7:0]};
        end else if (i_op[OP_UBYTE]) begin
            o_data = {24'd0, w_shr[7:0]};
        end else if (i_op[OP_HALF]) begin
            o_data = {{16{w_shr[15]}}, w_shr[15:0]};
        end else if (i_op[OP_UHALF]) begin
            o_data = {16'd0, w_shr[15:0]};
        end else if (i_op[OP_LEFT]) begin
            o_data  = w_shl;
            o_wstrb = strb_lookup(LWL_STRB_TBL, i_addr_lo);
        end else if (i_op[OP_RIGHT]) begin
            o_data  = w_shr;
            o_wstrb = strb_lookup(LWR_STRB_TBL, i_addr_lo);
        end
    end

endmodule

// File: rtl/mem_resp_tracker.sv
// Tracks outstanding data-bus requests in issue order and turns in-order
// bus responses into registered GPR load writes.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req_fire/req_ready request handshake (ready = not full)
//   req_load/op/addr_lo/dest  attributes recorded with each request
//   flush              cancels every in-flight request
//   data_ok/rdata      in-order response strobe and data
//   ld_valid/data/wstrb/dest  registered load result, one cycle after data_ok
//   st_pending         an uncancelled store is outstanding
//   occupancy          outstanding entry count
//   spurious_err       sticky: a response arrived with nothing outstanding
module mem_resp_tracker
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_fire,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [6:0]       req_op,
    input  logic [1:0]       req_addr_lo,
    input  logic [4:0]       req_dest,
    input  logic             flush,
    input  logic             data_ok,
    input  logic [31:0]      rdata,
    output logic             ld_valid,
    output logic [31:0]      ld_data,
    output logic [3:0]       ld_wstrb,
    output logic [4:0]       ld_dest,
    output logic             st_pending,
    output logic [CNT_W-1:0] occupancy,
    output logic             spurious_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           r_fifo [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_st_cnt;
    logic             r_spurious;
    logic             r_ld_valid_p1;
    logic [31:0]      r_ld_data_p1;
    logic [3:0]       r_ld_wstrb_p1;
    logic [4:0]       r_ld_dest_p1;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;
    logic             w_pop_load;
    logic             w_pop_store;
    logic             w_push_store;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [31:0]      w_align_data;
    logic [3:0]       w_align_strb;

    assign w_full  = (r_occ == FULL_CNT);
    assign w_empty = (r_occ == '0);
    // No push-through-pop when full: ready depends only on current occupancy.
    assign w_push  = req_fire && !w_full;
    assign w_pop   = data_ok && !w_empty;
    assign w_head  = r_fifo[r_head];

    // A flush coinciding with the response cancels the head too.
    assign w_pop_load   = w_pop && w_head.load && !w_head.cancelled && !flush;
    assign w_pop_store  = w_pop && !w_head.load && !w_head.cancelled;
    assign w_push_store = w_push && !req_load && !flush;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    assign w_head_nxt = (r_head == LAST_PTR) ? '0 : r_head + PTR_ONE;
    assign w_tail_nxt = (r_tail == LAST_PTR) ? '0 : r_tail + PTR_ONE;

    mem_load_align u_align (
        .i_op      (w_head.op),
        .i_addr_lo (w_head.addr_lo),
        .i_rdata   (rdata),
        .o_data    (w_align_data),
        .o_wstrb   (w_align_strb)
    );

    // Entry storage: flush marks every slot (free slots are rewritten on
    // push anyway); a same-cycle push lands already cancelled.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i].cancelled <= 1'b1;
            end
        end
        if (w_push) begin
            r_fifo[r_tail] <= '{load: req_load, op: req_op, addr_lo: req_addr_lo,
                                dest: req_dest, cancelled: flush};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_st_cnt   <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_push) r_tail <= w_tail_nxt;
            if (w_pop)  r_head <= w_head_nxt;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CNT_ONE;
                2'b01:   r_occ <= r_occ - CNT_ONE;
                default: r_occ <= r_occ;
            endcase
            if (flush) begin
                r_st_cnt <= '0;
            end else begin
                case ({w_push_store, w_pop_store})
                    2'b10:   r_st_cnt <= r_st_cnt + CNT_ONE;
                    2'b01:   r_st_cnt <= r_st_cnt - CNT_ONE;
                    default: r_st_cnt <= r_st_cnt;
                endcase
            end
            if (data_ok && w_empty) r_spurious <= 1'b1;
        end
    end

    // Stage p1: registered load result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_valid_p1 <= 1'b0;
            r_ld_data_p1  <= '0;
            r_ld_wstrb_p1 <= '0;
            r_ld_dest_p1  <= '0;
        end else begin
            r_ld_valid_p1 <= w_pop_load;
            if (w_pop_load) begin
                r_ld_data_p1  <= w_align_data;
                r_ld_wstrb_p1 <= w_align_strb;
                r_ld_dest_p1  <= w_head.dest;
            end
        end
    end

    assign req_ready    = !w_full;
    assign occupancy    = r_occ;
    assign st_pending   = (r_st_cnt != '0);
    assign spurious_err = r_spurious;
    assign ld_valid     = r_ld_valid_p1;
    assign ld_data      = r_ld_data_p1;
    assign ld_wstrb     = r_ld_wstrb_p1;
    assign ld_dest      = r_ld_dest_p1;

endmodule

// File: tb/tb_mem_resp_tracker.sv
module tb_mem_resp_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] W  = 7'b0000001;
    localparam logic [6:0] B  = 7'b0000010;
    localparam logic [6:0] BU = 7'b0000100;
    localparam logic [6:0] H  = 7'b0001000;
    localparam logic [6:0] HU = 7'b0010000;
    localparam logic [6:0] L  = 7'b0100000;
    localparam logic [6:0] R  = 7'b1000000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_fire = 1'b0;
    logic             req_ready;
    logic             req_load = 1'b0;
    logic [6:0]       req_op = '0;
    logic [1:0]       req_addr_lo = '0;
    logic [4:0]       req_dest = '0;
    logic             flush = 1'b0;
    logic             data_ok = 1'b0;
    logic [31:0]      rdata = '0;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic [3:0]       ld_wstrb;
    logic [4:0]       ld_dest;
    logic             st_pending;
    logic [CNT_W-1:0] occupancy;
    logic             spurious_err;

    mem_resp_tracker #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_fire     (req_fire),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_op       (req_op),
        .req_addr_lo  (req_addr_lo),
        .req_dest     (req_dest),
        .flush        (flush),
        .data_ok      (data_ok),
        .rdata        (rdata),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_wstrb     (ld_wstrb),
        .ld_dest      (ld_dest),
        .st_pending   (st_pending),
        .occupancy    (occupancy),
        .spurious_err (spurious_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       canc;
        logic [6:0] op;
        logic [1:0] a;
        logic [4:0] d;
    } ment_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [4:0]  dest;
    } exp_t;

    ment_t mq[$];
    exp_t  eq[$];
    logic  m_sp = 1'b0;
    logic  exp_v = 1'b0;
    int    n_pass = 0;
    int    n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h, need %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input ment_t e, input logic [31:0] rd);
        exp_t        r;
        logic [31:0] s;
        logic [3:0]  t;
        int          k;
        k = int'(e.a);
        s = rd >> (8 * k);
        r.dest = e.d;
        r.data = rd;
        r.strb = 4'b1111;
        if (e.op == B)       r.data = {{24{s[7]}}, s[7:0]};
        else if (e.op == BU) r.data = {24'd0, s[7:0]};
        else if (e.op == H)  r.data = {{16{s[15]}}, s[15:0]};
        else if (e.op == HU) r.data = {16'd0, s[15:0]};
        else if (e.op == L) begin
            r.data = rd << (8 * (3 - k));
            t = 4'b1111;
            r.strb = t << (3 - k);
        end else if (e.op == R) begin
            r.data = s;
            t = 4'b1111;
            r.strb = t >> k;
        end
        return r;
    endfunction

    function automatic logic model_st();
        foreach (mq[i]) if (!mq[i].ld && !mq[i].canc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("ld_valid", 32'(ld_valid), 32'(exp_v));
        if (exp_v) begin
            e = eq.pop_front();
            chk("ld_data", ld_data, e.data);
            chk("ld_wstrb", 32'(ld_wstrb), 32'(e.strb));
            chk("ld_dest", 32'(ld_dest), 32'(e.dest));
        end
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("req_ready", 32'(req_ready), 32'(mq.size() != DEPTH));
        chk("st_pending", 32'(st_pending), 32'(model_st()));
        chk("spurious_err", 32'(spurious_err), 32'(m_sp));
    endtask

    task automatic cyc(input logic fire, input logic ld, input logic [6:0] op,
                       input logic [1:0] a, input logic [4:0] d,
                       input logic fl, input logic dok, input logic [31:0] rd);
        ment_t h;
        logic  do_pop;
        logic  do_push;
        do_pop  = dok && (mq.size() != 0);
        do_push = fire && (mq.size() != DEPTH);
        exp_v   = 1'b0;
        if (dok && mq.size() == 0) m_sp = 1'b1;
        if (fl) foreach (mq[i]) mq[i].canc = 1'b1;
        if (do_pop) begin
            h = mq.pop_front();
            if (h.ld && !h.canc) begin
                exp_v = 1'b1;
                eq.push_back(model(h, rd));
            end
        end
        if (do_push) mq.push_back('{ld, fl, op, a, d});
        req_fire = fire; req_load = ld; req_op = op; req_addr_lo = a; req_dest = d;
        flush = fl; data_ok = dok; rdata = rd;
        tick();
        req_fire = 1'b0; flush = 1'b0; data_ok = 1'b0;
        check_outputs();
    endtask

    task automatic push(input logic ld, input logic [6:0] op, input logic [1:0] a, input logic [4:0] d);
        cyc(1'b1, ld, op, a, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resp(input logic [31:0] rd);
        cyc(1'b0, 1'b0, W, 2'd0, 5'd0, 1'b0, 1'b1, rd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_fire = 1'b0; flush = 1'b0; data_ok = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mq.delete();
        eq.delete();
        m_sp  = 1'b0;
        exp_v = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_outputs();
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_ld_wstrb", 32'(ld_wstrb), 32'h0);
        chk("rst_ld_dest", 32'(ld_dest), 32'h0);

        // lb, addr_lo=2
        push(1'b1, B, 2'd2, 5'd3);
        resp(32'h0080_0000);
        chk("lb_data", ld_data, 32'hFFFF_FF80);
        chk("lb_wstrb", 32'(ld_wstrb), 32'hF);

        // lwl, addr_lo=1
        push(1'b1, L, 2'd1, 5'd4);
        resp(32'hAABB_CCDD);
        chk("lwl_data", ld_data, 32'hCCDD_0000);
        chk("lwl_wstrb", 32'(ld_wstrb), 32'hC);

        // Other ops, pipelined back to back
        push(1'b1, HU, 2'd2, 5'd5);
        push(1'b1, R, 2'd3, 5'd6);
        push(1'b1, BU, 2'd3, 5'd7);
        resp(32'h8001_1234);
        resp(32'h1122_3344);
        resp(32'hF0E0_D0C0);
        push(1'b1, H, 2'd0, 5'd8);
        push(1'b1, W, 2'd0, 5'd9);
        resp(32'h0000_8765);
        resp(32'hDEAD_BEEF);

        // Fill to DEPTH, overflow attempt ignored, then drain
        push(1'b1, W, 2'd0, 5'd10);
        push(1'b1, B, 2'd1, 5'd11);
        push(1'b1, L, 2'd3, 5'd12);
        push(1'b1, R, 2'd0, 5'd13);
        chk("full_ready", 32'(req_ready), 32'h0);
        push(1'b1, W, 2'd0, 5'd31);
        resp(32'h0102_0304);
        chk("after_pop_occ", 32'(occupancy), 32'd3);
        chk("after_pop_ready", 32'(req_ready), 32'h1);
        resp(32'h0000_8000);
        resp(32'h5566_7788);
        resp(32'h99AA_BBCC);

        // Flush with a same-cycle push cancels everything
        push(1'b1, W, 2'd0, 5'd1);
        push(1'b1, W, 2'd0, 5'd2);
        cyc(1'b1, 1'b0, W, 2'd0, 5'd3, 1'b1, 1'b0, 32'h0);
        resp(32'h1111_1111);
        resp(32'h2222_2222);
        resp(32'h3333_3333);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_st", 32'(st_pending), 32'h0);

        // Store then load
        push(1'b0, W, 2'd0, 5'd0);
        push(1'b1, W, 2'd0, 5'd14);
        chk("st_pend_on", 32'(st_pending), 32'h1);
        resp(32'h0);
        chk("st_pend_off", 32'(st_pending), 32'h0);
        chk("st_no_ld", 32'(ld_valid), 32'h0);
        resp(32'hCAFE_F00D);
        chk("ld_after_st", 32'(ld_valid), 32'h1);

        // Flush coinciding with the response suppresses the head
        push(1'b1, W, 2'd0, 5'd15);
        cyc(1'b0, 1'b0, W, 2'd0, 5'd0, 1'b1, 1'b1, 32'h7777_7777);

        // Reset mid-operation discards entries
        push(1'b1, W, 2'd0, 5'd16);
        push(1'b0, W, 2'd0, 5'd0);
        do_reset();
        check_outputs();
        resp(32'h0);
        chk("rst_spurious", 32'(spurious_err), 32'h1);

        // Sticky error holds through later traffic
        push(1'b1, B, 2'd0, 5'd17);
        resp(32'h0000_00FF);
        tick();
        chk("sticky_hold", 32'(spurious_err), 32'h1);
        do_reset();
        chk("sticky_clear", 32'(spurious_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_resp_tracker.md
MEM_RESP_TRACKER -- requirements
Module: mem_resp_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding data-bus transactions (2..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), meaning the occupancy counter width.
REQ-003 SHALL have port clk  in  1  clock; reset is synchronous, active-high, on port reset  in  1.
REQ-004 SHALL have port req_fire  in  1  data request accepted by the bus this cycle.
REQ-005 SHALL have port req_ready  out  1  tracker can record a new request (not full).
REQ-006 SHALL have port req_load  in  1  request is a load (0 = store).
REQ-007 SHALL have port req_op  in  7  one-hot {right,left,uhalf,half,ubyte,byte,word}.
REQ-008 SHALL have port req_addr_lo  in  2  address bits [1:0].
REQ-009 SHALL have port req_dest  in  5  destination GPR.
REQ-010 SHALL have port flush  in  1  exception/eret cancel of all in-flight requests.
REQ-011 SHALL have port data_ok  in  1  in-order bus response strobe.
REQ-012 SHALL have port rdata  in  32  response read data.
REQ-013 SHALL have port ld_valid  out  1  one-cycle pulse with a completed load.
REQ-014 SHALL have port ld_data  out  32  aligned, extended load result.
REQ-015 SHALL have port ld_wstrb  out  4  GPR byte write enables.
REQ-016 SHALL have port ld_dest  out  5  GPR index.
REQ-017 SHALL have port st_pending  out  1  at least one uncancelled store outstanding.
REQ-018 SHALL have port occupancy  out  CNT_W  number of outstanding entries.
REQ-019 SHALL have port spurious_err  out  1  sticky flag: data_ok received while empty.

Function
REQ-020 SHALL hold a circular FIFO of DEPTH entries {load, op, addr_lo, dest, cancelled} with wrapping head/tail pointers.
REQ-021 SHALL drive req_ready = (occupancy != DEPTH); a push does not bypass when full, even if a pop occurs the same cycle.
REQ-022 SHALL push on req_fire && req_ready; req_fire while full SHALL be ignored and SHALL NOT corrupt state.
REQ-023 SHALL pop the head entry on data_ok when occupancy != 0.
REQ-024 SHALL update occupancy +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-025 SHALL register the outputs: ld_valid rises exactly one cycle after the data_ok that pops an uncancelled load.
REQ-026 SHALL consume store responses and cancelled-entry responses silently, with ld_valid = 0.
REQ-027 SHALL set cancelled in every occupied entry on flush, and SHALL enqueue a same-cycle push already cancelled.
REQ-028 SHALL suppress the head when flush and data_ok coincide, with no ld_valid.
REQ-029 SHALL shift ld_data for byte/ubyte/half/uhalf as rdata >> (addr_lo*8), sign- or zero-extended from bit 7 or 15.
REQ-030 SHALL form ld_data as rdata << ((~addr_lo)*8) for left (lwl), rdata >> (addr_lo*8) for right (lwr), and rdata for word.
REQ-031 SHALL set ld_wstrb for lwl by addr_lo 0..3 to 1000/1100/1110/1111, for lwr to 1111/0111/0011/0001, and otherwise to 1111.
REQ-032 SHALL derive st_pending from a separate counter of uncancelled outstanding stores; flush clears that counter.
REQ-033 SHALL set spurious_err on data_ok while occupancy == 0 and hold it until reset.

Reset
REQ-034 SHALL on reset zero the head, tail, occupancy and store counter, and drive ld_valid=0, ld_data=0, ld_wstrb=0, ld_dest=0, spurious_err=0 and req_ready=1.
REQ-035 SHALL discard all entries on reset mid-operation, so that a data_ok in the following cycle sets spurious_err.

Structure
REQ-036 SHALL place the op one-hot bit indices and the lwl/lwr strobe tables in shared package mem_pkg.
REQ-037 SHALL implement REQ-029 to REQ-031 in the combinational sub-module mem_load_align.

Verification
REQ-038 SHALL cover: lb with addr_lo=2 and rdata=0x00800000 -> one cycle after data_ok, ld_data=0xFFFFFF80 and ld_wstrb=1111.
REQ-039 SHALL cover: lwl with addr_lo=1 and rdata=0xAABBCCDD -> ld_data=0xCCDD0000 and ld_wstrb=1100.
REQ-040 SHALL cover: DEPTH=4 with 4 pushes -> req_ready=0, a 5th req_fire ignored, and after one data_ok occupancy=3 and req_ready=1.
REQ-041 SHALL cover: 2 loads outstanding, then flush together with a push, then 3 data_ok -> no ld_valid, occupancy=0 and st_pending=0.
REQ-042 SHALL cover: store, then load, then data_ok x2 -> st_pending falls after the first response and ld_valid occurs only after the second.
REQ-043 SHALL cover: data_ok while empty -> spurious_err=1 and held until reset.
